// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score keeper
package score_pkg;
   typedef enum logic [0:0] {PLAY = 1'b0, OVER = 1'b1} state_t;
   localparam int BCD_DIGITS = 4;
   localparam logic [15:0] BCD_MAX = 16'h9999;
   typedef logic [15:0] bcd16_t;
endpackage

// File: rtl/bcd_add4.sv
// rtl/bcd_add4.sv - combinational 4-digit packed-BCD plus single-digit adder
module bcd_add4
   import score_pkg::*;
(
   input  bcd16_t     a,
   input  logic [3:0] b,
   output bcd16_t     sum,
   output logic       ovf
);
   logic [3:0] carry;
   logic [4:0] t;
   logic [4:0] t_adj;

   // carry starts as the addend and ripples as 0/1 through the upper digits
   always_comb begin
      carry = b;
      t     = 5'd0;
      t_adj = 5'd0;
      sum   = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         t     = {1'b0, a[i*4 +: 4]} + {1'b0, carry};
         t_adj = t - 5'd10;
         if (t > 5'd9) begin
            sum[i*4 +: 4] = t_adj[3:0];
            carry         = 4'd1;
         end else begin
            sum[i*4 +: 4] = t[3:0];
            carry         = 4'd0;
         end
      end
      ovf = (carry != 4'd0);
   end
endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD hit score with combo bonus and game-over freeze
// Optional best-score register enabled by SCORE_BEST_EN.
module score_keeper
   import score_pkg::*;
#(
   parameter int COMBO_WIN = 50000000,
   parameter int COMBO_PTS = 2,
   parameter int BASE_PTS  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hit,
   input  logic        miss,
   input  logic        start,
   output logic [15:0] grade,
   output logic        lose,
   output logic        combo,
   output logic [15:0] best
);
   localparam int WW = $clog2(COMBO_WIN + 1);

   state_t        state;
   logic          hit_q;
   logic [WW-1:0] win_cnt;
   logic          hit_rise;
   logic [3:0]    pts;
   bcd16_t        add_sum;
   logic          add_ovf;
   bcd16_t        grade_next;

   assign hit_rise   = hit & ~hit_q;
   assign combo      = (win_cnt != '0);
   assign pts        = combo ? 4'(COMBO_PTS) : 4'(BASE_PTS);
   assign grade_next = add_ovf ? BCD_MAX : add_sum;

   bcd_add4 u_add (
      .a   (grade),
      .b   (pts),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= PLAY;
         grade   <= 16'h0000;
         lose    <= 1'b0;
         hit_q   <= 1'b0;
         win_cnt <= '0;
      end else begin
         hit_q <= hit;
         case (state)
            PLAY: begin
               // miss outranks start, which outranks a hit
               if (miss) begin
                  state   <= OVER;
                  lose    <= 1'b1;
                  win_cnt <= '0;
               end else if (start) begin
                  grade   <= 16'h0000;
                  win_cnt <= '0;
               end else if (hit_rise) begin
                  grade   <= grade_next;
                  win_cnt <= WW'(COMBO_WIN - 1);
               end else if (combo) begin
                  win_cnt <= win_cnt - WW'(1);
               end
            end
            default: begin
               win_cnt <= '0;
               if (start && !miss) begin
                  state <= PLAY;
                  grade <= 16'h0000;
                  lose  <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef SCORE_BEST_EN
   bcd16_t best_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_q <= 16'h0000;
      end else if (state == PLAY && miss && grade > best_q) begin
         best_q <= grade;
      end
   end

   assign best = best_q;
`else
   assign best = 16'h0000;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed vector bench for score_keeper
module tb_score_keeper;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hit = 1'b0;
   logic        miss = 1'b0;
   logic        start = 1'b0;
   logic [15:0] grade;
   logic        lose;
   logic        combo;
   logic [15:0] best;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        h;
      logic        m;
      logic        s;
      logic [15:0] g;
      logic        l;
      logic        c;
   } vec_t;

   vec_t vq[$];

   score_keeper #(.COMBO_WIN(4), .COMBO_PTS(2), .BASE_PTS(1)) dut (
      .clk   (clk),
      .rst   (rst),
      .hit   (hit),
      .miss  (miss),
      .start (start),
      .grade (grade),
      .lose  (lose),
      .combo (combo),
      .best  (best)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic h, input logic m, input logic s);
      hit   = h;
      miss  = m;
      start = s;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic base_hit();
      step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic add(input logic h, input logic m, input logic s,
                      input logic [15:0] g, input logic l, input logic c);
      vec_t v;
      v.h = h; v.m = m; v.s = s; v.g = g; v.l = l; v.c = c;
      vq.push_back(v);
   endtask

   logic [15:0] exp_best;

   initial begin
      // single 3-cycle pulse, then a 10-cycle held level
      add(0,0,0,16'h0000,0,0);
      add(1,0,0,16'h0001,0,1);
      add(1,0,0,16'h0001,0,1);
      add(1,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,0);
      add(0,0,0,16'h0001,0,0);
      add(0,0,1,16'h0000,0,0);
      add(1,0,0,16'h0001,0,1);
      add(1,0,0,16'h0001,0,1);
      add(1,0,0,16'h0001,0,1);
      for (int i = 0; i < 7; i++) add(1,0,0,16'h0001,0,0);
      add(0,0,0,16'h0001,0,0);
      add(0,0,1,16'h0000,0,0);
      // rises 2 cycles apart: combo bonus
      add(1,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,1);
      add(1,0,0,16'h0003,0,1);
      add(0,0,0,16'h0003,0,1);
      add(0,0,0,16'h0003,0,1);
      add(0,0,0,16'h0003,0,0);
      add(0,0,1,16'h0000,0,0);
      // rises 6 cycles apart: no bonus
      add(1,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,0);
      add(0,0,0,16'h0001,0,0);
      add(0,0,0,16'h0001,0,0);
      add(1,0,0,16'h0002,0,1);
      add(0,0,0,16'h0002,0,1);
      add(0,0,1,16'h0000,0,0);
      // build 5, then miss with a simultaneous hit
      add(1,0,0,16'h0001,0,1);
      add(0,0,0,16'h0001,0,1);
      add(1,0,0,16'h0003,0,1);
      add(0,0,0,16'h0003,0,1);
      add(1,0,0,16'h0005,0,1);
      add(0,0,0,16'h0005,0,1);
      add(1,1,0,16'h0005,1,0);
      add(0,0,0,16'h0005,1,0);
      add(1,0,0,16'h0005,1,0);
      add(0,1,0,16'h0005,1,0);
      add(0,0,1,16'h0000,0,0);
      add(0,0,0,16'h0000,0,0);
      // start beats hit in PLAY; start with miss stays in OVER
      add(1,0,1,16'h0000,0,0);
      add(0,0,0,16'h0000,0,0);
      add(0,1,0,16'h0000,1,0);
      add(0,1,1,16'h0000,1,0);
      add(0,0,1,16'h0000,0,0);

      #2;
      chk("rst_grade", grade, 16'h0000);
      chk("rst_lose", {15'd0, lose}, 16'd0);
      chk("rst_combo", {15'd0, combo}, 16'd0);
      chk("rst_best", best, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vq[i]) begin
         step(vq[i].h, vq[i].m, vq[i].s);
         chk($sformatf("vec%0d_grade", i), grade, vq[i].g);
         chk($sformatf("vec%0d_lose", i), {15'd0, lose}, {15'd0, vq[i].l});
         chk($sformatf("vec%0d_combo", i), {15'd0, combo}, {15'd0, vq[i].c});
      end

      // decimal carry
      repeat (9) base_hit();
      chk("carry_0009", grade, 16'h0009);
      base_hit();
      chk("carry_0010", grade, 16'h0010);

      // saturation
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4998; i++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      chk("sat_9997", grade, 16'h9997);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("sat_9998", grade, 16'h9998);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("sat_9999", grade, 16'h9999);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("sat_hold", grade, 16'h9999);

      // best score across games
      step(1'b0, 1'b0, 1'b1);
      repeat (7) base_hit();
      chk("best_g7", grade, 16'h0007);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (3) base_hit();
      chk("best_g3", grade, 16'h0003);
      step(1'b0, 1'b1, 1'b0);
`ifdef SCORE_BEST_EN
      exp_best = 16'h0007;
`else
      exp_best = 16'h0000;
`endif
      chk("best_val", best, exp_best);

      // async reset mid-combo at 42
      step(1'b0, 1'b0, 1'b1);
      base_hit();
      for (int i = 0; i < 21; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i != 20) step(1'b0, 1'b0, 1'b0);
      end
      chk("pre_rst_grade", grade, 16'h0042);
      chk("pre_rst_combo", {15'd0, combo}, 16'd1);
      hit = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_grade", grade, 16'h0000);
      chk("arst_combo", {15'd0, combo}, 16'd0);
      chk("arst_lose", {15'd0, lose}, 16'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0);
      chk("post_rst_hit", grade, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream producer of the 16-bit `grade` value consumed by the Display7 seven-segment driver.
- Counts ball-paddle hits as 4-digit packed BCD and awards combo bonus points for rapid consecutive hits.
- Freezes the score on game over and drives the `lose` level that Display7 uses to halt its timer.
- Optionally keeps a best-score register across games.

Parameters:
- COMBO_WIN, 50000000: combo window in clk cycles (0.5 s at 100 MHz); minimum 1.
- COMBO_PTS, 2: points per hit while the combo window is active; range 1..9.
- BASE_PTS, 1: points per hit outside the combo window; range 1..9.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  Asynchronous reset, active-high; clears all state.
- hit  in  1  Level from collision logic; one rising edge = one hit.
- miss  in  1  Ball lost (level); ends the game.
- start  in  1  Single-cycle pulse; begins a new game.
- grade  out  16  Current score, packed BCD, 4 digits; goes to Display7 `grade`.
- lose  out  1  High while in OVER; goes to Display7 `lose`.
- combo  out  1  High while the combo window counter is non-zero.
- best  out  16  Best score, packed BCD (see Optional Feature).

Behaviour:
- Reset values: state=PLAY, grade=16'h0000, lose=0, combo=0, best=16'h0000, hit_q=0, win_cnt=0.
- Edge detect:
  - hit_q is registered from hit every cycle.
  - hit_rise = hit & ~hit_q, evaluated combinationally from the current hit and hit_q.
  - A level held high counts once only.
- State PLAY:
  - On hit_rise (and miss=0): grade <= sat(grade + pts) at the same edge, so the new score is visible 1 cycle after hit first samples high.
  - pts = COMBO_PTS if win_cnt != 0 at that edge, else BASE_PTS.
  - win_cnt <= COMBO_WIN - 1 on every accepted hit; otherwise win_cnt decrements to 0 and holds there.
  - combo = (win_cnt != 0).
- PLAY -> OVER when miss=1.
  - Priority: miss beats hit in the same cycle; that hit is dropped.
  - At the transition edge: lose <= 1, win_cnt <= 0.
- State OVER:
  - grade is held; hit and miss are ignored; win_cnt stays 0.
- OVER -> PLAY on start=1 (and miss=0): grade <= 0, lose <= 0, win_cnt <= 0, hit_q unaffected.
  - If start and miss are high in the same cycle, remain in OVER.
- start while in PLAY: grade <= 0, win_cnt <= 0.
  - If start and hit are high in the same cycle, start wins and the hit is dropped.
  - If start and miss are high in the same cycle, miss wins.
- BCD arithmetic:
  - Per-digit add with decimal carry: a digit sum above 9 subtracts 10 and carries 1 into the next digit.
  - A carry out of digit 3 means overflow; sat() then forces grade = 16'h9999, which holds on further hits.
  - Inputs are always valid BCD, so the outputs are always valid BCD.
- Reset mid-game: asynchronous; all outputs reach their reset values immediately with no clock required; the game resumes in PLAY.
- win_cnt width: $clog2(COMBO_WIN+1).

Optional Feature:
- Macro: SCORE_BEST_EN.
- Defined: on the PLAY->OVER edge, best <= grade if grade > best. A plain 16-bit unsigned compare is correct for valid BCD. best survives start; only rst clears it.
- Undefined: the best register is not built and the best output is tied to 16'h0000.

Decomposition:
- Package score_pkg:
  - state enum {PLAY, OVER};
  - BCD_DIGITS=4;
  - BCD_MAX=16'h9999;
  - typedef bcd16_t for a 16-bit packed-BCD value.
- Sub-module bcd_add4: combinational.
  - Inputs: bcd16_t a, 4-bit addend b.
  - Outputs: bcd16_t sum, 1-bit ovf.
  - Instantiated once.
- All sequencing stays in score_keeper.

Test Plan (COMBO_WIN=4, COMBO_PTS=2, BASE_PTS=1 for simulation):
- Reset then a single hit pulse of 3 cycles -> grade=0001 one cycle after the rise, combo=1 for 3 cycles, then combo=0; hit held high for 10 cycles still gives 0001.
- Two rises 2 cycles apart -> grade 0001 then 0003. Two rises 6 cycles apart -> 0001 then 0002.
- Preload to 0009 via 9 spaced hits, then one more hit -> grade=0010 (decimal carry). Reach 9998, then a combo hit -> 9999 (saturated); a further hit stays at 9999.
- grade=0005, then miss and hit in the same cycle -> lose=1, grade=0005. Hits during OVER leave 0005. start -> lose=0, grade=0000 the next cycle.
- Score 0007 then miss, start, score 0003 then miss -> best=0007. With SCORE_BEST_EN undefined -> best=0000 throughout.
- Assert rst asynchronously between clock edges while grade=0042 and combo=1 -> grade=0000, combo=0, lose=0 before the next clk edge.
